// File: rtl/fp_wb_pkg.sv
// Shared types and constants for the FP writeback arbiter.
package fp_wb_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned IDX_W     = 5;
    localparam int unsigned NUM_FREGS = 32;

    typedef struct packed {
        logic [IDX_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } fp_wb_t;

endpackage

// File: rtl/fp_wb_fifo.sv
// Small synchronous FIFO of writeback records; holds FPU results that lost arbitration.
module fp_wb_fifo
    import fp_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  logic   pop,
    input  fp_wb_t wdata,
    output fp_wb_t rdata,
    output logic   full,
    output logic   empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    fp_wb_t            mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fp_wb_arbiter.sv
// FP register-file writeback arbiter: load > skid FIFO head > direct FPU, plus pending-write
// scoreboard. Define FP_WB_BYPASS_EN to add write-cycle forwarding to the decode read ports.
module fp_wb_arbiter
    import fp_wb_pkg::*;
#(
    parameter int unsigned DATA_W     = fp_wb_pkg::DATA_W,
    parameter int unsigned IDX_W      = fp_wb_pkg::IDX_W,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic [IDX_W-1:0]  issue_rd,
    input  logic              ld_wb_en,
    input  logic [IDX_W-1:0]  ld_rd,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              fpu_valid,
    input  logic [IDX_W-1:0]  fpu_rd,
    input  logic [DATA_W-1:0] fpu_data,
    output logic              fpu_ready,
    output logic              wb_en,
    output logic [IDX_W-1:0]  rd_index,
    output logic [DATA_W-1:0] wb_data,
    input  logic [IDX_W-1:0]  rs1_index,
    input  logic [IDX_W-1:0]  rs2_index,
`ifdef FP_WB_BYPASS_EN
    input  logic [DATA_W-1:0] rs1_rf_data,
    input  logic [DATA_W-1:0] rs2_rf_data,
    output logic [DATA_W-1:0] rs1_fwd_data,
    output logic [DATA_W-1:0] rs2_fwd_data,
`endif
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              rd_busy
);

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    fp_wb_t               fifo_head;
    fp_wb_t               fpu_in;
    fp_wb_t               win;
    logic                 win_valid;
    logic                 win_is_fpu;
    logic                 fpu_fire;
    logic [NUM_FREGS-1:0] pending;
    logic [NUM_FREGS-1:0] pending_d;
    logic                 rs1_wb_hit;
    logic                 rs2_wb_hit;

    assign fpu_in    = '{rd: fpu_rd, data: fpu_data};
    assign fpu_ready = ~fifo_full;
    assign fpu_fire  = fpu_valid & fpu_ready;

    always_comb begin
        win        = fpu_in;
        win_valid  = 1'b0;
        win_is_fpu = 1'b0;
        fifo_pop   = 1'b0;
        fifo_push  = 1'b0;
        if (ld_wb_en) begin
            win       = '{rd: ld_rd, data: ld_data};
            win_valid = 1'b1;
            fifo_push = fpu_fire;
        end else if (!fifo_empty) begin
            // Older buffered results go first so FPU results retire in acceptance order.
            win        = fifo_head;
            win_valid  = 1'b1;
            win_is_fpu = 1'b1;
            fifo_pop   = 1'b1;
            fifo_push  = fpu_fire;
        end else if (fpu_fire) begin
            win_valid  = 1'b1;
            win_is_fpu = 1'b1;
        end
    end

    always_comb begin
        pending_d = pending;
        if (win_is_fpu)  pending_d[win.rd]   = 1'b0;
        if (issue_valid) pending_d[issue_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en    <= 1'b0;
            rd_index <= '0;
            wb_data  <= '0;
            pending  <= '0;
        end else begin
            wb_en   <= win_valid;
            pending <= pending_d;
            if (win_valid) begin
                rd_index <= win.rd;
                wb_data  <= win.data;
            end
        end
    end

    assign rs1_wb_hit = wb_en & (rd_index == rs1_index);
    assign rs2_wb_hit = wb_en & (rd_index == rs2_index);
    assign rd_busy    = pending[issue_rd];

`ifdef FP_WB_BYPASS_EN
    assign rs1_fwd_data = rs1_wb_hit ? wb_data : rs1_rf_data;
    assign rs2_fwd_data = rs2_wb_hit ? wb_data : rs2_rf_data;
    assign rs1_busy     = pending[rs1_index];
    assign rs2_busy     = pending[rs2_index];
`else
    // The regfile write lands at the end of the wb cycle, so that cycle still counts as busy.
    assign rs1_busy = pending[rs1_index] | rs1_wb_hit;
    assign rs2_busy = pending[rs2_index] | rs2_wb_hit;
`endif

    fp_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fpu_in),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
